midi_voice_alloc: RTL and testbench
===================================

Name: midi_voice_alloc

Overview:
- Polyphonic voice allocator between midi_in and the per-voice chains (note_pitch2dds / dds32 / adsr32 / vca8).
- Consumes the one-clock channel-message strobe from midi_in. Maintains a table of VOICES voices, each holding gate, note and velocity.
- Replaces the single-voice reg_rs gate and reg7 note latch.
- Allocation: repeated note reuses its voice; otherwise the least-recently-allocated free voice; otherwise steal the least-recently-allocated voice.

Parameters:
- VOICES, 4: number of voices; power of two, 2..8.
- CHANNEL, 0: MIDI channel accepted (0..15); other channels ignored.

Ports:
- clk  in  1  system clock (clk50PLL domain).
- rst_n  in  1  synchronous reset, active-low.
- ch_message  in  4  message type from midi_in; nonzero for exactly one clk when a message completes, 4'b0000 otherwise.
- chan  in  4  channel of the message; valid while ch_message != 0.
- note  in  7  note number (note on/off); valid with ch_message.
- velocity  in  7  velocity (note on/off); valid with ch_message.
- lsb  in  7  controller number for CC (4'b1011); valid with ch_message.
- msb  in  7  controller value for CC; valid with ch_message.
- gate  out  VOICES  per-voice gate, bit i = voice i.
- voice_note  out  7*VOICES  note of voice i at bits [7i+6:7i].
- voice_vel  out  7*VOICES  velocity of voice i, same packing.
- retrig  out  VOICES  one-clk pulse when voice i is (re)assigned by a note-on.

Behaviour:
- All state updates on rising clk. Outputs are registered. Latency: strobe in cycle N -> gate/voice_note/voice_vel/retrig valid in cycle N+1.
- Reset (rst_n=0 at an edge):
  - gate=0, voice_note=0, voice_vel=0, retrig=0.
  - rank[i]=VOICES-1-i, so voice 0 is allocated first.
  - Reset mid-stream discards that cycle's strobe.
- Message acceptance: only when ch_message != 0 and chan == CHANNEL. Otherwise no state change and retrig=0.
- rank[i] is a permutation of 0..VOICES-1; higher rank means older allocation. Width $clog2(VOICES).
- Note-on (4'b1001, velocity != 0):
  1. If a voice with gate=1 has voice_note==note, reuse it (lowest index if several): update velocity, pulse retrig, gate stays 1.
  2. Else, among voices with gate=0, pick the highest rank.
  3. Else (all gated) steal the highest rank.
  - Chosen voice k: gate[k]=1, note/vel loaded, retrig[k]=1.
  - Rank update: every voice with rank < rank[k] increments; rank[k]=0.
- Note-off (4'b1000), or note-on with velocity==0: every voice with gate=1 and voice_note==note gets gate=0. Note/vel retained so release tails keep pitch. Ranks unchanged.
- Note-off with no matching voice: no change.
- CC (4'b1011) with lsb==123 (all notes off): all gates 0, ranks unchanged.
- Other CCs and messages (pitch bend 4'b1110, program, pressure): ignored here; pitch is still handled by reg14w.
- retrig is 0 in every cycle without an accepted note-on; at most one bit set.
- Simultaneous events cannot occur (one message per strobe). Back-to-back strobes on consecutive clks are processed in order with no loss.

Optional Feature:
- Macro SUSTAIN_PEDAL_EN.
- Defined:
  - Extra state: sustain flag (CC lsb==64; msb>=64 -> down, else up) and a per-voice held bit.
  - Note-off while pedal down: voice keeps gate=1 and sets held.
  - Pedal up: every held voice gets gate=0 and held cleared.
  - A note-on to a voice clears its held bit.
  - CC123 clears gates and held bits; pedal state unchanged.
  - Allocation treats held voices as gated.
- Undefined: CC64 ignored, no held state, note-off clears gate immediately.

Test Plan:
- Reset, then note-on ch0 note 60 vel 100 -> cycle after strobe: gate=4'b0001, voice0 note=60 vel=100, retrig=4'b0001 for one clk.
- Note-ons 60, 62, 64, 65, then 67 (VOICES=4) -> voices 0..3 hold 60..65; 67 steals voice 0; gate=4'b1111, retrig=4'b0001.
- Notes 60, 62 held; note-off 60; note-on 70 -> 70 goes to voice 2 (highest-rank free), not voice 0. Voice 0 keeps note 60 with gate 0.
- Note-on 60 vel 0 after note-on 60 -> gate bit cleared. Note-on on ch 5 with CHANNEL=0 -> no output change, retrig=0.
- Four notes held, then CC lsb=123 -> gate=4'b0000 next cycle. Strobes on consecutive clks (on 60, on 62) -> both voices allocated.
- With SUSTAIN_PEDAL_EN: note-on 60, CC64 msb=127, note-off 60 -> gate stays 1; CC64 msb=0 -> gate 0 next cycle. Without the macro, the same sequence gives gate 0 right after the note-off.

Source files
------------

// File: rtl/midi_voice_alloc_if.sv
// Channel-message bus from midi_in plus the per-voice outputs of midi_voice_alloc.
// The master side drives the message strobe; the slave side (the allocator) drives the voice table.
interface midi_voice_alloc_if #(
  parameter int VOICES = 4
);
  logic [3:0]          ch_message;
  logic [3:0]          chan;
  logic [6:0]          note;
  logic [6:0]          velocity;
  logic [6:0]          lsb;
  logic [6:0]          msb;
  logic [VOICES-1:0]   gate;
  logic [7*VOICES-1:0] voice_note;
  logic [7*VOICES-1:0] voice_vel;
  logic [VOICES-1:0]   retrig;

  modport master (
    output ch_message, chan, note, velocity, lsb, msb,
    input  gate, voice_note, voice_vel, retrig
  );

  modport slave (
    input  ch_message, chan, note, velocity, lsb, msb,
    output gate, voice_note, voice_vel, retrig
  );
endinterface

// File: rtl/midi_voice_alloc.sv
// Polyphonic voice allocator: note reuse, else oldest free voice, else steal the oldest voice.
// Optional sustain pedal (CC64) with per-voice held bits when SUSTAIN_PEDAL_EN is defined.
module midi_voice_alloc #(
  parameter int VOICES  = 4,
  parameter int CHANNEL = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  midi_voice_alloc_if.slave  bus
);

  localparam int RW = (VOICES > 1) ? $clog2(VOICES) : 1;

  localparam logic [3:0] MSG_NOTE_OFF = 4'b1000;
  localparam logic [3:0] MSG_NOTE_ON  = 4'b1001;
  localparam logic [3:0] MSG_CC       = 4'b1011;
  localparam logic [3:0] MSG_NONE     = 4'b0000;
  localparam logic [6:0] CC_ALL_OFF   = 7'd123;
  localparam logic [3:0] CHAN_SEL     = 4'(CHANNEL);

  logic [VOICES-1:0] gate_r;
  logic [VOICES-1:0] gate_s;
  logic [VOICES-1:0] retrig_r;
  logic [VOICES-1:0] retrig_s;
  logic [6:0]        note_r [VOICES];
  logic [6:0]        note_s [VOICES];
  logic [6:0]        vel_r  [VOICES];
  logic [6:0]        vel_s  [VOICES];
  logic [RW-1:0]     rank_r [VOICES];
  logic [RW-1:0]     rank_s [VOICES];

`ifdef SUSTAIN_PEDAL_EN
  localparam logic [6:0] CC_SUSTAIN = 7'd64;
  logic [VOICES-1:0] held_r;
  logic [VOICES-1:0] held_s;
  logic              sustain_r;
  logic              sustain_s;
`endif

  logic              accept_s;
  logic              note_on_s;
  logic              note_off_s;
  logic              cc_s;
  logic [VOICES-1:0] match_s;
  logic              reuse_found_s;
  logic [RW-1:0]     reuse_idx_s;
  logic              free_found_s;
  logic [RW-1:0]     free_idx_s;
  logic [RW-1:0]     free_rank_s;
  logic [RW-1:0]     steal_idx_s;
  logic [RW-1:0]     pick_s;

  // Message decode: only strobes on our channel count; velocity 0 note-on acts as note-off.
  always_comb begin
    accept_s   = (bus.ch_message != MSG_NONE) && (bus.chan == CHAN_SEL);
    note_on_s  = accept_s && (bus.ch_message == MSG_NOTE_ON) && (bus.velocity != 7'd0);
    note_off_s = accept_s && ((bus.ch_message == MSG_NOTE_OFF) ||
                              ((bus.ch_message == MSG_NOTE_ON) && (bus.velocity == 7'd0)));
    cc_s       = accept_s && (bus.ch_message == MSG_CC);
  end

  // Voice selection; held voices keep gate=1 so they count as busy without extra logic.
  always_comb begin
    match_s       = '0;
    reuse_found_s = 1'b0;
    reuse_idx_s   = '0;
    free_found_s  = 1'b0;
    free_idx_s    = '0;
    free_rank_s   = '0;
    steal_idx_s   = '0;
    // Descending scan so the lowest matching index is the one left standing.
    for (int i = VOICES - 1; i >= 0; i--) begin
      match_s[i] = gate_r[i] && (note_r[i] == bus.note);
      if (match_s[i]) begin
        reuse_found_s = 1'b1;
        reuse_idx_s   = RW'(i);
      end else begin
        reuse_found_s = reuse_found_s;
      end
    end
    for (int i = 0; i < VOICES; i++) begin
      if (!gate_r[i] && (!free_found_s || (rank_r[i] > free_rank_s))) begin
        free_found_s = 1'b1;
        free_idx_s   = RW'(i);
        free_rank_s  = rank_r[i];
      end else begin
        free_found_s = free_found_s;
      end
      if (rank_r[i] == RW'(VOICES - 1)) begin
        steal_idx_s = RW'(i);
      end else begin
        steal_idx_s = steal_idx_s;
      end
    end
    if (reuse_found_s) begin
      pick_s = reuse_idx_s;
    end else if (free_found_s) begin
      pick_s = free_idx_s;
    end else begin
      pick_s = steal_idx_s;
    end
  end

  // Next state of the voice table for the current message.
  always_comb begin
    gate_s   = gate_r;
    note_s   = note_r;
    vel_s    = vel_r;
    rank_s   = rank_r;
    retrig_s = '0;
`ifdef SUSTAIN_PEDAL_EN
    held_s    = held_r;
    sustain_s = sustain_r;
`endif
    if (note_on_s) begin
      // Everything newer than the chosen voice ages by one; the chosen voice becomes newest.
      for (int i = 0; i < VOICES; i++) begin
        if (rank_r[i] < rank_r[pick_s]) begin
          rank_s[i] = rank_r[i] + RW'(1);
        end else begin
          rank_s[i] = rank_r[i];
        end
      end
      rank_s[pick_s]   = '0;
      gate_s[pick_s]   = 1'b1;
      note_s[pick_s]   = bus.note;
      vel_s[pick_s]    = bus.velocity;
      retrig_s[pick_s] = 1'b1;
`ifdef SUSTAIN_PEDAL_EN
      held_s[pick_s]   = 1'b0;
`endif
    end else if (note_off_s) begin
`ifdef SUSTAIN_PEDAL_EN
      if (sustain_r) begin
        held_s = held_r | match_s;
      end else begin
        gate_s = gate_r & ~match_s;
      end
`else
      gate_s = gate_r & ~match_s;
`endif
    end else if (cc_s && (bus.lsb == CC_ALL_OFF)) begin
      gate_s = '0;
`ifdef SUSTAIN_PEDAL_EN
      held_s = '0;
`endif
`ifdef SUSTAIN_PEDAL_EN
    end else if (cc_s && (bus.lsb == CC_SUSTAIN)) begin
      sustain_s = bus.msb[6];
      if (!bus.msb[6]) begin
        gate_s = gate_r & ~held_r;
        held_s = '0;
      end else begin
        held_s = held_r;
      end
`endif
    end else begin
      gate_s = gate_r;
    end
  end

  // Voice table registers; reset ranks make voice 0 the oldest, so it is allocated first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gate_r   <= '0;
      retrig_r <= '0;
      for (int i = 0; i < VOICES; i++) begin
        note_r[i] <= 7'd0;
        vel_r[i]  <= 7'd0;
        rank_r[i] <= RW'(VOICES - 1 - i);
      end
`ifdef SUSTAIN_PEDAL_EN
      held_r    <= '0;
      sustain_r <= 1'b0;
`endif
    end else begin
      gate_r   <= gate_s;
      retrig_r <= retrig_s;
      for (int i = 0; i < VOICES; i++) begin
        note_r[i] <= note_s[i];
        vel_r[i]  <= vel_s[i];
        rank_r[i] <= rank_s[i];
      end
`ifdef SUSTAIN_PEDAL_EN
      held_r    <= held_s;
      sustain_r <= sustain_s;
`endif
    end
  end

  assign bus.gate   = gate_r;
  assign bus.retrig = retrig_r;

  for (genvar g = 0; g < VOICES; g++) begin : g_pack
    assign bus.voice_note[7*g +: 7] = note_r[g];
    assign bus.voice_vel[7*g +: 7]  = vel_r[g];
  end

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Self-checking bench for midi_voice_alloc: directed scenarios plus randomized messages
// against an allocation-order queue model.
module tb_midi_voice_alloc;

  localparam int V = 4;
  localparam logic [3:0] ON  = 4'b1001;
  localparam logic [3:0] OFF = 4'b1000;
  localparam logic [3:0] CC  = 4'b1011;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  midi_voice_alloc_if #(.VOICES(V)) bus ();

  midi_voice_alloc #(.VOICES(V), .CHANNEL(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: order queue holds voice indices, oldest allocation at the front.
  int         order[$];
  bit         m_gate[V];
  bit         m_held[V];
  logic [6:0] m_note[V];
  logic [6:0] m_vel[V];
  bit         m_sus;
  logic [V-1:0] m_retrig;

  function automatic void model_reset();
    order.delete();
    for (int i = 0; i < V; i++) begin
      order.push_back(i);
      m_gate[i] = 1'b0;
      m_held[i] = 1'b0;
      m_note[i] = 7'd0;
      m_vel[i]  = 7'd0;
    end
    m_sus    = 1'b0;
    m_retrig = '0;
  endfunction

  function automatic void model_msg(logic [3:0] cm, logic [3:0] ch, logic [6:0] n,
                                    logic [6:0] v, logic [6:0] l, logic [6:0] m);
    int k;
    m_retrig = '0;
    if (cm == 4'd0 || ch != 4'd0) return;
    if (cm == ON && v != 7'd0) begin
      k = -1;
      for (int i = 0; i < V; i++)
        if (k < 0 && m_gate[i] && m_note[i] == n) k = i;
      for (int j = 0; j < order.size(); j++)
        if (k < 0 && !m_gate[order[j]]) k = order[j];
      if (k < 0) k = order[0];
      for (int j = 0; j < order.size(); j++)
        if (order[j] == k) begin
          order.delete(j);
          break;
        end
      order.push_back(k);
      m_gate[k]   = 1'b1;
      m_held[k]   = 1'b0;
      m_note[k]   = n;
      m_vel[k]    = v;
      m_retrig[k] = 1'b1;
    end else if (cm == OFF || cm == ON) begin
      for (int i = 0; i < V; i++)
        if (m_gate[i] && m_note[i] == n) begin
`ifdef SUSTAIN_PEDAL_EN
          if (m_sus) m_held[i] = 1'b1;
          else m_gate[i] = 1'b0;
`else
          m_gate[i] = 1'b0;
`endif
        end
    end else if (cm == CC && l == 7'd123) begin
      for (int i = 0; i < V; i++) begin
        m_gate[i] = 1'b0;
        m_held[i] = 1'b0;
      end
    end else if (cm == CC && l == 7'd64) begin
`ifdef SUSTAIN_PEDAL_EN
      m_sus = (m >= 7'd64);
      if (!m_sus)
        for (int i = 0; i < V; i++)
          if (m_held[i]) begin
            m_gate[i] = 1'b0;
            m_held[i] = 1'b0;
          end
`endif
    end
  endfunction

  function automatic logic [16*V-1:0] exp_all();
    logic [V-1:0]   g;
    logic [7*V-1:0] nn;
    logic [7*V-1:0] vv;
    for (int i = 0; i < V; i++) begin
      g[i]        = m_gate[i];
      nn[7*i +: 7] = m_note[i];
      vv[7*i +: 7] = m_vel[i];
    end
    return {g, nn, vv, m_retrig};
  endfunction

  function automatic logic [16*V-1:0] act_all();
    return {bus.gate, bus.voice_note, bus.voice_vel, bus.retrig};
  endfunction

  task automatic drive(input logic [3:0] cm, input logic [3:0] ch, input logic [6:0] n,
                       input logic [6:0] v, input logic [6:0] l, input logic [6:0] m);
    @(negedge clk);
    bus.ch_message = cm;
    bus.chan       = ch;
    bus.note       = n;
    bus.velocity   = v;
    bus.lsb        = l;
    bus.msb        = m;
    model_msg(cm, ch, n, v, l, m);
    @(posedge clk);
    #1;
  endtask

  task automatic note_on(input logic [6:0] n, input logic [6:0] v);
    drive(ON, 4'd0, n, v, 7'd0, 7'd0);
  endtask

  task automatic note_off(input logic [6:0] n);
    drive(OFF, 4'd0, n, 7'd64, 7'd0, 7'd0);
  endtask

  task automatic cc(input logic [6:0] l, input logic [6:0] m);
    drive(CC, 4'd0, 7'd0, 7'd0, l, m);
  endtask

  task automatic idle();
    drive(4'd0, 4'd0, 7'd0, 7'd0, 7'd0, 7'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    bus.ch_message = ON;
    bus.chan       = 4'd0;
    bus.note       = 7'd99;
    bus.velocity   = 7'd99;
    bus.lsb        = 7'd0;
    bus.msb        = 7'd0;
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.ch_message = 4'd0;
    rst_n          = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (act_all() !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected 0", act_all());
    end
    note_on(7'd50, 7'd10);
    note_on(7'd51, 7'd11);
    do_reset();
    vectors++;
    if (act_all() !== '0) begin
      miscompares++;
      $display("FAIL reset_midstream: got %h expected 0", act_all());
    end
    note_on(7'd52, 7'd12);
    vectors++;
    if (bus.retrig !== 4'b0001 || act_all() !== exp_all()) begin
      miscompares++;
      $display("FAIL reset_rank: got %h expected %h", act_all(), exp_all());
    end
    idle();
  endtask

  task automatic test_first_note();
    do_reset();
    note_on(7'd60, 7'd100);
    vectors++;
    if (bus.gate !== 4'b0001 || bus.voice_note[6:0] !== 7'd60 ||
        bus.voice_vel[6:0] !== 7'd100 || bus.retrig !== 4'b0001) begin
      miscompares++;
      $display("FAIL first_note: got %h expected gate=1 note=60 vel=100 retrig=1", act_all());
    end
    idle();
    vectors++;
    if (bus.retrig !== 4'b0000 || act_all() !== exp_all()) begin
      miscompares++;
      $display("FAIL retrig_pulse: got %h expected %h", act_all(), exp_all());
    end
  endtask

  task automatic test_steal();
    do_reset();
    note_on(7'd60, 7'd1);
    note_on(7'd62, 7'd2);
    note_on(7'd64, 7'd3);
    note_on(7'd65, 7'd4);
    vectors++;
    if (bus.voice_note !== {7'd65, 7'd64, 7'd62, 7'd60}) begin
      miscompares++;
      $display("FAIL fill_voices: got %h expected %h", bus.voice_note, {7'd65, 7'd64, 7'd62, 7'd60});
    end
    note_on(7'd67, 7'd5);
    vectors++;
    if (bus.gate !== 4'b1111 || bus.retrig !== 4'b0001 || bus.voice_note[6:0] !== 7'd67) begin
      miscompares++;
      $display("FAIL steal: got %h expected gate=f retrig=1 v0=67", act_all());
    end
    idle();
  endtask

  task automatic test_free_pick();
    do_reset();
    note_on(7'd60, 7'd30);
    note_on(7'd62, 7'd31);
    note_off(7'd60);
    note_on(7'd70, 7'd32);
    vectors++;
    if (bus.retrig !== 4'b0100 || bus.gate !== 4'b0110 || bus.voice_note[6:0] !== 7'd60 ||
        act_all() !== exp_all()) begin
      miscompares++;
      $display("FAIL free_pick: got %h expected %h", act_all(), exp_all());
    end
    idle();
  endtask

  task automatic test_vel0_and_chan();
    do_reset();
    note_on(7'd60, 7'd90);
    drive(ON, 4'd0, 7'd60, 7'd0, 7'd0, 7'd0);
    vectors++;
    if (bus.gate !== 4'b0000 || bus.voice_note[6:0] !== 7'd60) begin
      miscompares++;
      $display("FAIL vel0_off: got %h expected gate=0 v0 note=60", act_all());
    end
    drive(ON, 4'd5, 7'd61, 7'd80, 7'd0, 7'd0);
    vectors++;
    if (bus.retrig !== 4'b0000 || bus.gate !== 4'b0000 || act_all() !== exp_all()) begin
      miscompares++;
      $display("FAIL other_chan: got %h expected %h", act_all(), exp_all());
    end
    idle();
  endtask

  task automatic test_all_off();
    do_reset();
    note_on(7'd40, 7'd1);
    note_on(7'd41, 7'd1);
    note_on(7'd42, 7'd1);
    note_on(7'd43, 7'd1);
    cc(7'd123, 7'd0);
    vectors++;
    if (bus.gate !== 4'b0000 || act_all() !== exp_all()) begin
      miscompares++;
      $display("FAIL all_notes_off: got %h expected %h", act_all(), exp_all());
    end
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    note_on(7'd60, 7'd20);
    vectors++;
    if (bus.retrig !== 4'b0001) begin
      miscompares++;
      $display("FAIL b2b_first: got retrig %b expected 0001", bus.retrig);
    end
    note_on(7'd62, 7'd21);
    vectors++;
    if (bus.gate !== 4'b0011 || bus.retrig !== 4'b0010 || bus.voice_note[13:7] !== 7'd62) begin
      miscompares++;
      $display("FAIL b2b_second: got %h expected gate=3 retrig=2 v1=62", act_all());
    end
    idle();
  endtask

  task automatic test_sustain();
    logic [V-1:0] exp_after_off;
    do_reset();
`ifdef SUSTAIN_PEDAL_EN
    exp_after_off = 4'b0001;
`else
    exp_after_off = 4'b0000;
`endif
    note_on(7'd60, 7'd100);
    cc(7'd64, 7'd127);
    note_off(7'd60);
    vectors++;
    if (bus.gate !== exp_after_off) begin
      miscompares++;
      $display("FAIL sustain_off: got gate %b expected %b", bus.gate, exp_after_off);
    end
    cc(7'd64, 7'd0);
    vectors++;
    if (bus.gate !== 4'b0000 || act_all() !== exp_all()) begin
      miscompares++;
      $display("FAIL sustain_up: got %h expected %h", act_all(), exp_all());
    end
    idle();
  endtask

  task automatic test_random();
    logic [3:0] cm;
    logic [3:0] ch;
    logic [6:0] l;
    do_reset();
    for (int it = 0; it < 600; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: cm = ON;
        4, 5:       cm = OFF;
        6, 7:       cm = CC;
        8:          cm = 4'b1110;
        default:    cm = 4'd0;
      endcase
      ch = ($urandom_range(0, 9) < 8) ? 4'd0 : 4'($urandom_range(1, 15));
      case ($urandom_range(0, 2))
        0:       l = 7'd123;
        1:       l = 7'd64;
        default: l = 7'($urandom_range(0, 127));
      endcase
      drive(cm, ch, 7'($urandom_range(60, 67)),
            ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(1, 127)),
            l, 7'($urandom_range(0, 127)));
      vectors++;
      if (act_all() !== exp_all()) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h expected %h", it, act_all(), exp_all());
      end
    end
    idle();
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst_n          = 1'b0;
    bus.ch_message = 4'd0;
    bus.chan       = 4'd0;
    bus.note       = 7'd0;
    bus.velocity   = 7'd0;
    bus.lsb        = 7'd0;
    bus.msb        = 7'd0;
    model_reset();
    test_reset();
    test_first_note();
    test_steal();
    test_free_pick();
    test_vel0_and_chan();
    test_all_off();
    test_back_to_back();
    test_sustain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
